link_rx_deserializer: RTL and testbench

- Receive stage for the console's 2-pin serial input link (uio_in[7:6]); the companion stage to the 2-pin transmit path on uio_out[5:4].
- Registers the two rx pins, detects a start bit, then shifts in WORD_BITS of payload at 2 bits per clock.
- Presents each completed word on a one-entry valid/ready output buffer to the console core.
- Flags overruns when the core does not drain the buffer in time.

---
 rtl/link_rx_deserializer.sv | 116 +++++++++++
 tb/tb_link_rx_deserializer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/link_rx_deserializer.sv
// Receive stage of the 2-pin serial console link: start-bit detect, 2-bit-per-clock
// deserialization, and a one-entry valid/ready output buffer with sticky overrun.
module link_rx_deserializer #(
    parameter int WORD_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           rx_pins,
    output logic [WORD_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 overrun,
    input  logic                 clr_overrun
);

    localparam int N     = WORD_BITS / 2;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    // Handshake: a word transfers on any edge where out_valid=1 and out_ready=1;
    // out_data is held stable while out_valid=1 and out_ready=0.
    typedef enum logic {
        IDLE,
        RECV
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             rx_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WORD_BITS-1:0]   shift_q, shift_d;
    logic [WORD_BITS-1:0]   out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   complete;
    logic                   drop;
    logic [WORD_BITS-1:0]   word;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rx_q        <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_q        <= rx_pins;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        complete    = 1'b0;
        drop        = 1'b0;
        // The final chunk goes straight from rx_q into the word, bypassing shift.
        word                     = shift_q;
        word[WORD_BITS-1 -: 2]   = rx_q;

        case (state_q)
            IDLE: begin
                if (rx_q[0]) begin
                    state_d = RECV;
                    cnt_d   = '0;
                end
            end
            RECV: begin
                shift_d[{cnt_q, 1'b0} +: 2] = rx_q;
                if (cnt_q == CNT_LAST) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = word;
                out_valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // A drop on the same edge as a clear leaves the flag set.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == RECV);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_link_rx_deserializer.sv
// Directed bench for link_rx_deserializer: reset, single word, start filter,
// back-to-back reception, overrun and coincident clear/drop.
module tb_link_rx_deserializer;

    localparam int W = 16;
    localparam int N = W / 2;

    logic         clk;
    logic         rst_n;
    logic [1:0]   rx_pins;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         overrun;
    logic         clr_overrun;

    int check_cnt = 0;
    int pass_cnt  = 0;

    link_rx_deserializer #(.WORD_BITS(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_pins    (rx_pins),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .overrun    (overrun),
        .clr_overrun(clr_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_chunks(input logic [W-1:0] w);
        for (int i = 0; i < N; i++) begin
            rx_pins = w[2*i +: 2];
            tick();
        end
    endtask

    task automatic test_reset();
        logic seen_valid;
        rst_n = 1'b0; rx_pins = 2'b00; out_ready = 1'b0; clr_overrun = 1'b0;
        tick(); tick();
        check_cnt++;
        if ({out_valid, busy, overrun} !== 3'b000 || out_data !== 16'h0000)
            $display("FAIL reset_state: got v/b/o=%b data=%h expected 000 data=0000",
                     {out_valid, busy, overrun}, out_data);
        else pass_cnt++;
        rst_n = 1'b1;
        // Start bit plus three chunks, then reset mid-message.
        rx_pins = 2'b01; tick();
        rx_pins = 2'b11; tick();
        rx_pins = 2'b10; tick();
        rx_pins = 2'b01; tick();
        check_cnt++;
        if (busy !== 1'b1) $display("FAIL mid_msg_busy: got %b expected 1", busy);
        else pass_cnt++;
        rst_n = 1'b0; rx_pins = 2'b00; tick();
        rst_n = 1'b1;
        check_cnt++;
        if ({out_valid, busy, overrun} !== 3'b000)
            $display("FAIL reset_mid_msg: got v/b/o=%b expected 000", {out_valid, busy, overrun});
        else pass_cnt++;
        seen_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid || busy) seen_valid = 1'b1;
        end
        check_cnt++;
        if (seen_valid !== 1'b0) $display("FAIL reset_no_word: got activity=%b expected 0", seen_valid);
        else pass_cnt++;
    endtask

    task automatic test_single_word();
        logic busy_ok;
        out_ready = 1'b1;
        rx_pins = 2'b01; tick();
        check_cnt++;
        if (busy !== 1'b0) $display("FAIL single_busy_e0: got %b expected 0", busy);
        else pass_cnt++;
        busy_ok = 1'b1;
        for (int i = 0; i < N; i++) begin
            rx_pins = 16'hA5C3 >> (2*i);
            tick();
            if (busy !== 1'b1 || out_valid !== 1'b0) busy_ok = 1'b0;
        end
        check_cnt++;
        if (busy_ok !== 1'b1) $display("FAIL single_busy_window: got ok=%b expected 1", busy_ok);
        else pass_cnt++;
        rx_pins = 2'b00; tick();
        check_cnt++;
        if (out_valid !== 1'b1 || out_data !== 16'hA5C3 || busy !== 1'b0)
            $display("FAIL single_word_e9: got v=%b b=%b data=%h expected v=1 b=0 data=a5c3",
                     out_valid, busy, out_data);
        else pass_cnt++;
        tick();
        check_cnt++;
        if (out_valid !== 1'b0 || out_data !== 16'hA5C3)
            $display("FAIL single_consume_e10: got v=%b data=%h expected v=0 data=a5c3", out_valid, out_data);
        else pass_cnt++;
    endtask

    task automatic test_start_filter();
        logic quiet;
        out_ready = 1'b1;
        rx_pins = 2'b10;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy || out_valid) quiet = 1'b0;
        end
        check_cnt++;
        if (quiet !== 1'b1) $display("FAIL idle_10_filter: got quiet=%b expected 1", quiet);
        else pass_cnt++;
        rx_pins = 2'b11; tick();
        send_chunks(16'hA5C3);
        check_cnt++;
        if (busy !== 1'b1) $display("FAIL start11_busy: got %b expected 1", busy);
        else pass_cnt++;
        rx_pins = 2'b00; tick();
        check_cnt++;
        if (out_valid !== 1'b1 || out_data !== 16'hA5C3)
            $display("FAIL start11_word: got v=%b data=%h expected v=1 data=a5c3", out_valid, out_data);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        rx_pins = 2'b01; tick();
        send_chunks(16'h1234);
        rx_pins = 2'b01; tick();
        check_cnt++;
        if (out_valid !== 1'b1 || out_data !== 16'h1234)
            $display("FAIL b2b_first: got v=%b data=%h expected v=1 data=1234", out_valid, out_data);
        else pass_cnt++;
        rx_pins = 2'b11; tick();
        check_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL b2b_gapless: got v=%b b=%b expected v=0 b=1", out_valid, busy);
        else pass_cnt++;
        for (int i = 1; i < N; i++) begin
            rx_pins = 2'b11; tick();
        end
        rx_pins = 2'b01; tick();
        check_cnt++;
        if (out_valid !== 1'b1 || out_data !== 16'hFFFF || overrun !== 1'b0)
            $display("FAIL b2b_second: got v=%b data=%h o=%b expected v=1 data=ffff o=0",
                     out_valid, out_data, overrun);
        else pass_cnt++;
        // Third word completes on the same edge the held second word is taken.
        out_ready = 1'b0;
        send_chunks(16'h5A0F);
        check_cnt++;
        if (out_valid !== 1'b1 || out_data !== 16'hFFFF)
            $display("FAIL b2b_hold: got v=%b data=%h expected v=1 data=ffff", out_valid, out_data);
        else pass_cnt++;
        out_ready = 1'b1; rx_pins = 2'b00; tick();
        check_cnt++;
        if (out_valid !== 1'b1 || out_data !== 16'h5A0F || overrun !== 1'b0)
            $display("FAIL b2b_replace: got v=%b data=%h o=%b expected v=1 data=5a0f o=0",
                     out_valid, out_data, overrun);
        else pass_cnt++;
        out_ready = 1'b0; tick();
        check_cnt++;
        if (out_valid !== 1'b1) $display("FAIL b2b_stay_valid: got %b expected 1", out_valid);
        else pass_cnt++;
        out_ready = 1'b1; tick();
        check_cnt++;
        if (out_valid !== 1'b0 || out_data !== 16'h5A0F)
            $display("FAIL b2b_drain: got v=%b data=%h expected v=0 data=5a0f", out_valid, out_data);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        out_ready = 1'b0; clr_overrun = 1'b0;
        rx_pins = 2'b01; tick();
        send_chunks(16'h0001);
        rx_pins = 2'b01; tick();
        check_cnt++;
        if (out_valid !== 1'b1 || out_data !== 16'h0001 || overrun !== 1'b0)
            $display("FAIL ovr_first: got v=%b data=%h o=%b expected v=1 data=0001 o=0",
                     out_valid, out_data, overrun);
        else pass_cnt++;
        send_chunks(16'h0002);
        rx_pins = 2'b00; tick();
        check_cnt++;
        if (out_valid !== 1'b1 || out_data !== 16'h0001 || overrun !== 1'b1)
            $display("FAIL ovr_drop: got v=%b data=%h o=%b expected v=1 data=0001 o=1",
                     out_valid, out_data, overrun);
        else pass_cnt++;
        tick(); tick(); tick();
        check_cnt++;
        if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b expected 1", overrun);
        else pass_cnt++;
        clr_overrun = 1'b1; tick();
        clr_overrun = 1'b0;
        check_cnt++;
        if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b expected 0", overrun);
        else pass_cnt++;
        // Third word dropped on the same edge as a clear request.
        rx_pins = 2'b01; tick();
        send_chunks(16'h0003);
        rx_pins = 2'b00; clr_overrun = 1'b1; tick();
        clr_overrun = 1'b0;
        check_cnt++;
        if (overrun !== 1'b1 || out_data !== 16'h0001)
            $display("FAIL ovr_set_wins: got o=%b data=%h expected o=1 data=0001", overrun, out_data);
        else pass_cnt++;
        clr_overrun = 1'b1; tick();
        clr_overrun = 1'b0;
        check_cnt++;
        if (overrun !== 1'b0) $display("FAIL ovr_clear2: got %b expected 0", overrun);
        else pass_cnt++;
        out_ready = 1'b1; tick();
        check_cnt++;
        if (out_valid !== 1'b0 || out_data !== 16'h0001)
            $display("FAIL ovr_drain: got v=%b data=%h expected v=0 data=0001", out_valid, out_data);
        else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; rx_pins = 2'b00; out_ready = 1'b0; clr_overrun = 1'b0;
        test_reset();
        test_single_word();
        test_start_filter();
        test_back_to_back();
        test_overrun();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
